// File: rtl/bmp_rx_pkg.sv
// Shared types and constants for the BMP pixel stream receiver.
package bmp_rx_pkg;

   localparam int unsigned MAX_CH_DEF = 4;
   localparam int unsigned CH_W       = 3;
   localparam int unsigned ERR_W      = 4;

   localparam int unsigned ERR_EOL_EARLY = 0;
   localparam int unsigned ERR_EOL_MISS  = 1;
   localparam int unsigned ERR_SOF       = 2;
   localparam int unsigned ERR_CFG       = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_RECV     = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   // 8-bit complement (255 - b) when inversion is enabled; no carry possible.
   function automatic logic [7:0] invert_byte(input logic [7:0] b, input logic inv);
      return inv ? (8'hFF - b) : b;
   endfunction

endpackage

// File: rtl/bmp_pixel_pack.sv
// Assembles channel bytes into one pixel word and registers it for the write port.
module bmp_pixel_pack
   import bmp_rx_pkg::*;
#(
   parameter int unsigned MAX_CH = MAX_CH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_clear,
   input  logic                  i_take,
   input  logic                  i_restart,
   input  logic                  i_emit,
   input  logic [7:0]            i_data,
   input  logic                  i_invert,
   input  logic [CH_W-1:0]       i_channel,
   output logic                  o_last_c,
   output logic [8*MAX_CH-1:0]   o_wr_data
);

   logic [CH_W-1:0]     r_ch_cnt;
   logic [8*MAX_CH-1:0] r_asm;
   logic [8*MAX_CH-1:0] r_wr_data;

   logic [CH_W-1:0]     w_eff_ch;
   logic [7:0]          w_byte;
   logic [8*MAX_CH-1:0] w_word;

   // A start-of-frame byte always lands in position 0 of an empty word.
   assign w_eff_ch  = i_restart ? '0 : r_ch_cnt;
   assign o_last_c  = (w_eff_ch == (i_channel - CH_W'(1)));
   assign w_byte    = invert_byte(i_data, i_invert);
   assign o_wr_data = r_wr_data;

   // Merge the incoming byte into the partially assembled word.
   always_comb begin
      w_word = i_restart ? '0 : r_asm;
      for (int k = 0; k < int'(MAX_CH); k++) begin
         if (CH_W'(k) == w_eff_ch) begin
            w_word[8*k +: 8] = w_byte;
         end
      end
   end

   // Byte counter, assembly register and output word register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ch_cnt  <= '0;
         r_asm     <= '0;
         r_wr_data <= '0;
      end else if (i_clear) begin
         r_ch_cnt  <= '0;
         r_asm     <= '0;
      end else if (i_take) begin
         if (i_emit) begin
            r_wr_data <= w_word;
            r_asm     <= '0;
            r_ch_cnt  <= '0;
         end else begin
            r_asm     <= w_word;
            r_ch_cnt  <= w_eff_ch + CH_W'(1);
         end
      end
   end

endmodule

// File: rtl/bmp_pixel_rx.sv
// Byte-serial BMP pixel receiver: frame FSM, geometry counters and error tracking.
module bmp_pixel_rx
   import bmp_rx_pkg::*;
#(
   parameter int unsigned DIM_W  = 12,
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned MAX_CH = MAX_CH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [DIM_W-1:0]      cfg_width,
   input  logic [DIM_W-1:0]      cfg_height,
   input  logic [CH_W-1:0]       cfg_channel,
   input  logic                  cfg_invert,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [7:0]            s_data,
   input  logic                  s_sof,
   input  logic                  s_eol,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [8*MAX_CH-1:0]   wr_data,
   output logic                  busy,
   output logic                  done,
   output logic [ERR_W-1:0]      err
);

   state_t            r_state;
   logic [DIM_W-1:0]  r_width;
   logic [DIM_W-1:0]  r_height;
   logic [CH_W-1:0]   r_channel;
   logic              r_invert;
   logic [DIM_W-1:0]  r_x;
   logic [DIM_W-1:0]  r_y;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_s_ready;
   logic              r_wr_en;
   logic              r_busy;
   logic              r_done;
   logic [ERR_W-1:0]  r_err;

   logic              w_acc;
   logic              w_take;
   logic              w_restart;
   logic              w_clear;
   logic              w_cfg_ok;
   logic              w_last_px;
   logic              w_x_end;
   logic              w_y_end;
   logic              w_line_end;
   logic              w_eol_early;
   logic              w_emit;
   logic              w_next_line;
   logic [DIM_W-1:0]  w_eff_x;
   logic [DIM_W-1:0]  w_eff_y;
   logic [ADDR_W-1:0] w_eff_addr;
   logic [ADDR_W-1:0] w_eff_base;
   logic [ADDR_W-1:0] w_next_base;

   // Handshake qualification; outside a frame only an sof byte is taken.
   assign w_acc     = s_valid & r_s_ready;
   assign w_restart = w_acc & s_sof;
   assign w_take    = w_acc & ((r_state == ST_RECV) | s_sof);
   assign w_clear   = (r_state == ST_IDLE) & start;
   assign w_cfg_ok  = (cfg_width != '0) && (cfg_height != '0) && (cfg_channel != '0) &&
                      (32'(cfg_channel) <= MAX_CH);

   // An sof byte is evaluated at the origin of a restarted frame.
   assign w_eff_x     = s_sof ? '0 : r_x;
   assign w_eff_y     = s_sof ? '0 : r_y;
   assign w_eff_addr  = s_sof ? '0 : r_addr;
   assign w_eff_base  = s_sof ? '0 : r_base;
   assign w_next_base = w_eff_base + ADDR_W'(r_width);

   assign w_x_end     = (w_eff_x == (r_width - DIM_W'(1)));
   assign w_y_end     = (w_eff_y == (r_height - DIM_W'(1)));
   assign w_line_end  = w_last_px & w_x_end;
   assign w_eol_early = s_eol & ~w_line_end;
   assign w_emit      = w_take & (w_last_px | s_eol);
   assign w_next_line = w_take & (w_line_end | s_eol);

   assign s_ready = r_s_ready;
   assign wr_en   = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign busy    = r_busy;
   assign done    = r_done;
   assign err     = r_err;

   bmp_pixel_pack #(
      .MAX_CH (MAX_CH)
   ) u_pack (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clear   (w_clear),
      .i_take    (w_take),
      .i_restart (s_sof),
      .i_emit    (w_emit),
      .i_data    (s_data),
      .i_invert  (r_invert),
      .i_channel (r_channel),
      .o_last_c  (w_last_px),
      .o_wr_data (wr_data)
   );

   // Frame FSM with position counters, write strobe and sticky errors.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_width   <= '0;
         r_height  <= '0;
         r_channel <= '0;
         r_invert  <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_addr    <= '0;
         r_base    <= '0;
         r_wr_addr <= '0;
         r_s_ready <= 1'b0;
         r_wr_en   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= '0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_width   <= cfg_width;
                  r_height  <= cfg_height;
                  r_channel <= cfg_channel;
                  r_invert  <= cfg_invert;
                  r_x       <= '0;
                  r_y       <= '0;
                  r_addr    <= '0;
                  r_base    <= '0;
                  if (w_cfg_ok) begin
                     r_err     <= '0;
                     r_state   <= ST_WAIT_SOF;
                     r_s_ready <= 1'b1;
                     r_busy    <= 1'b1;
                  end else begin
                     r_err     <= ERR_W'(1) << ERR_CFG;
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_WAIT_SOF, ST_RECV: begin
               if (w_take) begin
                  r_state <= ST_RECV;
                  r_x     <= w_eff_x;
                  r_y     <= w_eff_y;
                  r_addr  <= w_eff_addr;
                  r_base  <= w_eff_base;
                  if (w_restart && (r_state == ST_RECV)) r_err[ERR_SOF] <= 1'b1;
                  if (w_line_end && !s_eol)              r_err[ERR_EOL_MISS] <= 1'b1;
                  if (w_eol_early)                       r_err[ERR_EOL_EARLY] <= 1'b1;
                  if (w_emit) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= w_eff_addr;
                  end
                  if (w_next_line) begin
                     r_x    <= '0;
                     r_y    <= w_eff_y + DIM_W'(1);
                     r_addr <= w_next_base;
                     r_base <= w_next_base;
                     if (w_y_end) begin
                        r_state   <= ST_DONE;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b0;
                     end
                  end else if (w_last_px) begin
                     r_x    <= w_eff_x + DIM_W'(1);
                     r_addr <= w_eff_addr + ADDR_W'(1);
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bmp_pixel_rx.sv
// Directed self-checking bench for bmp_pixel_rx.
module tb_bmp_pixel_rx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [11:0] cfg_width;
   logic [11:0] cfg_height;
   logic [2:0]  cfg_channel;
   logic        cfg_invert;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_sof;
   logic        s_eol;
   logic        wr_en;
   logic [19:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic [3:0]  err;

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   int done_cnt;
   int last_wr_cyc;
   int done_cyc;
   logic [19:0] got_a[$];
   logic [31:0] got_d[$];
   logic [19:0] exp_a[$];
   logic [31:0] exp_d[$];

   // Hand-computed pixel words for bytes 0..23, three channels per pixel.
   logic [31:0] tbl [8] = '{32'h00020100, 32'h00050403, 32'h00080706, 32'h000B0A09,
                            32'h000E0D0C, 32'h0011100F, 32'h00141312, 32'h00171615};
   logic [31:0] tbl_inv [8] = '{32'h00FDFEFF, 32'h00FAFBFC, 32'h00F7F8F9, 32'h00F4F5F6,
                                32'h00F1F2F3, 32'h00EEEFF0, 32'h00EBECED, 32'h00E8E9EA};

   bmp_pixel_rx u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .cfg_width   (cfg_width),
      .cfg_height  (cfg_height),
      .cfg_channel (cfg_channel),
      .cfg_invert  (cfg_invert),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_sof       (s_sof),
      .s_eol       (s_eol),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture writes and done pulses away from the active edge.
   always @(negedge clk) begin
      if (wr_en) begin
         got_a.push_back(wr_addr);
         got_d.push_back(wr_data);
         last_wr_cyc = cyc;
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk);
      #1;
      got_a.delete();
      got_d.delete();
      exp_a.delete();
      exp_d.delete();
      done_cnt    = 0;
      last_wr_cyc = -1;
      done_cyc    = -1;
      @(negedge clk);
   endtask

   task automatic do_start(input int w, input int h, input int ch, input logic inv);
      cfg_width   = 12'(w);
      cfg_height  = 12'(h);
      cfg_channel = 3'(ch);
      cfg_invert  = inv;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
   endtask

   // Present one byte and hold it until the edge that accepts it.
   task automatic send_byte(input int d, input logic sof, input logic eol);
      int n = 0;
      s_valid = 1'b1;
      s_data  = 8'(d);
      s_sof   = sof;
      s_eol   = eol;
      while (!s_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) check("ready_timeout", 32'(s_ready), 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_eol   = 1'b0;
   endtask

   task automatic send_std(input int junk);
      for (int j = 0; j < junk; j++) send_byte(8'hA0 + j, 1'b0, 1'b0);
      for (int i = 0; i < 24; i++) send_byte(i, i == 0, (i == 11) || (i == 23));
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input logic [3:0] exp_err);
      check({tag, "_nwr"}, 32'(got_a.size()), 32'(exp_a.size()));
      for (int i = 0; i < exp_a.size(); i++) begin
         if (i < got_a.size()) begin
            check({tag, "_addr"}, 32'(got_a[i]), 32'(exp_a[i]));
            check({tag, "_data"}, got_d[i], exp_d[i]);
         end
      end
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      if (exp_a.size() > 0) check({tag, "_done_lat"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; cfg_width = '0; cfg_height = '0;
      cfg_channel = '0; cfg_invert = 1'b0;
      s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eol = 1'b0;
      done_cnt = 0; last_wr_cyc = -1; done_cyc = -1;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(s_ready), 32'd0);
      check("rst_busy",  32'(busy),    32'd0);
      check("rst_wr_en", 32'(wr_en),   32'd0);
      check("rst_done",  32'(done),    32'd0);
      check("rst_err",   32'(err),     32'd0);
      check("rst_addr",  32'(wr_addr), 32'd0);
      check("rst_data",  wr_data,      32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Clean 4x2 frame, three channels.
      clear_mon();
      do_start(4, 2, 3, 1'b0);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_ready", 32'(s_ready), 32'd1);
      send_std(0);
      wait_done("t1");
      for (int p = 0; p < 8; p++) begin exp_a.push_back(20'(p)); exp_d.push_back(tbl[p]); end
      check_frame("t1", 4'b0000);

      // Same frame with byte inversion.
      clear_mon();
      do_start(4, 2, 3, 1'b1);
      send_std(0);
      wait_done("t2");
      for (int p = 0; p < 8; p++) begin exp_a.push_back(20'(p)); exp_d.push_back(tbl_inv[p]); end
      check_frame("t2", 4'b0000);

      // Junk bytes ahead of sof are dropped.
      clear_mon();
      do_start(4, 2, 3, 1'b0);
      send_std(3);
      wait_done("t3");
      for (int p = 0; p < 8; p++) begin exp_a.push_back(20'(p)); exp_d.push_back(tbl[p]); end
      check_frame("t3", 4'b0000);

      // Early eol on pixel 2 of line 0; line 1 starts at address 4.
      clear_mon();
      do_start(4, 2, 3, 1'b0);
      for (int i = 0; i < 21; i++) send_byte(i, i == 0, (i == 8) || (i == 20));
      wait_done("t4");
      for (int p = 0; p < 7; p++) begin
         exp_a.push_back(20'(p < 3 ? p : p + 1));
         exp_d.push_back(tbl[p]);
      end
      check_frame("t4", 4'b0001);

      // sof reasserted on byte 7 restarts the frame at address 0.
      clear_mon();
      do_start(4, 2, 3, 1'b0);
      for (int i = 0; i < 7; i++) send_byte(i, i == 0, 1'b0);
      for (int r = 0; r < 24; r++) send_byte(7 + r, r == 0, (r == 11) || (r == 23));
      wait_done("t5");
      exp_a.push_back(20'd0); exp_d.push_back(tbl[0]);
      exp_a.push_back(20'd1); exp_d.push_back(tbl[1]);
      for (int p = 0; p < 8; p++) begin
         exp_a.push_back(20'(p));
         exp_d.push_back(tbl[p] + 32'h00070707);
      end
      check_frame("t5", 4'b0100);

      // Out-of-range channel count is rejected without writes.
      clear_mon();
      do_start(4, 2, 5, 1'b0);
      wait_done("t6");
      check_frame("t6", 4'b1000);

      // Reset mid-frame abandons everything with no done pulse.
      clear_mon();
      do_start(4, 2, 3, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(i, i == 0, 1'b0);
      check("t7_pre_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("t7_ready", 32'(s_ready), 32'd0);
      check("t7_busy",  32'(busy),    32'd0);
      check("t7_wr_en", 32'(wr_en),   32'd0);
      check("t7_done",  32'(done),    32'd0);
      check("t7_err",   32'(err),     32'd0);
      check("t7_addr",  32'(wr_addr), 32'd0);
      check("t7_data",  wr_data,      32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("t7_no_done", 32'(done_cnt), 32'd0);
      check("t7_idle_ready", 32'(s_ready), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bmp_pixel_rx.md
Name: bmp_pixel_rx

Overview:
- Synthesizable receiver for a byte-serial BMP pixel stream, the other end of the testbench-side pixel producer.
- Accepts bytes with frame/line markers and checks geometry against a configured width × height × channel.
- Packs the channel bytes of each pixel into one word, optionally inverts each byte (255 − b), and writes pixels into a frame memory.
- Sits between the DPI-driven bench stream source and the frame buffer used for write-back to a result BMP.

Parameters:
- DIM_W, 12, width of cfg_width/cfg_height and internal x/y counters
- ADDR_W, 20, frame-memory pixel address width
- MAX_CH, 4, max bytes per pixel; wr_data width = 8*MAX_CH

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse, arms reception of one frame
- cfg_width  input  DIM_W  pixels per line, latched at start
- cfg_height  input  DIM_W  lines per frame, latched at start
- cfg_channel  input  3  bytes per pixel (1..MAX_CH), latched at start
- cfg_invert  input  1  1: store 255−byte, latched at start
- s_valid  input  1  stream byte valid
- s_ready  output  1  stream byte accepted when s_valid&&s_ready
- s_data  input  8  stream byte, BMP order (B,G,R[,A])
- s_sof  input  1  qualifies first byte of frame
- s_eol  input  1  qualifies last byte of each line
- wr_en  output  1  frame-memory write strobe
- wr_addr  output  ADDR_W  pixel index y*width+x
- wr_data  output  8*MAX_CH  packed pixel; first byte in bits[7:0], unused upper bytes 0
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame end
- err  output  4  sticky {cfg, sof, eol_missing, eol_early}, cleared on start

Behaviour:
- Reset (async, reset_n=0): state=IDLE; s_ready, wr_en, busy, done=0; wr_addr, wr_data, err, counters=0. Asserting reset mid-frame abandons the frame with no done pulse.
- FSM states: IDLE, WAIT_SOF, RECV, DONE.
- IDLE:
  - start latches cfg_* and clears err.
  - If width=0, height=0, channel=0 or channel>MAX_CH: set err[3] and go to DONE.
  - Otherwise go to WAIT_SOF. start in any other state is ignored.
- WAIT_SOF:
  - s_ready=1; busy=1.
  - Accepted bytes without s_sof are dropped with no error.
  - A byte with s_sof is processed as pixel byte 0 of line 0, and the FSM goes to RECV.
- RECV (s_ready=1, busy=1), per accepted byte:
  - Byte = invert ? 8'hFF−s_data : s_data. Shift into the pixel assembly register at byte position ch_cnt.
  - When ch_cnt==channel−1: next cycle wr_en=1, wr_addr=pixel index, wr_data=assembled word (latency 1 cycle from last byte accepted). Then ch_cnt=0, x++, addr++.
  - A pixel's write issues before or simultaneously with the next pixel's assembly; at most one write per channel bytes.
- EOL check on the last byte of a line (x==width−1 and ch_cnt==channel−1):
  - s_eol must be 1. If it is 0, set err[1] and still end the line.
  - s_eol=1 on any other byte: set err[0], write the partial pixel (missing bytes 0), and jump to the next line. Address = next line start (y+1)*width.
- Frame end: after the last byte of line height−1 (with its write), go to DONE.
- s_sof in RECV: set err[2] and restart at x=y=0, addr=0, with this byte as byte 0.
- s_sof and s_eol on the same byte: the sof rule takes priority, then that byte's eol is checked against its position in the restarted frame.
- DONE: done=1 for exactly one cycle, s_ready=0, busy=0, then IDLE.
- Arithmetic:
  - Address is an incremental counter, no multiplier; it wraps modulo 2^ADDR_W.
  - x/y compare against the latched cfg values. Byte inversion is 8-bit, with no carry.

Decomposition:
- Package bmp_rx_pkg: state enum, err bit index constants (ERR_EOL_EARLY=0, ERR_EOL_MISS=1, ERR_SOF=2, ERR_CFG=3), MAX_CH default.
- One sub-module, bmp_pixel_pack: byte assembly (ch_cnt, shift, invert, wr_data register). The top holds the FSM, x/y/addr counters and error logic.

Test Plan:
- 4×2, ch=3, invert=0, bytes 0..23 with sof on byte 0 and eol on bytes 11,23 → 8 writes: addr 0..7, wr_data[23:0]=24'h020100, 24'h050403…; done one cycle after last write; err=0.
- Same frame, invert=1 → first wr_data=24'hFDFEFF; done; err=0.
- 3 junk bytes before sof → dropped, no writes for them, identical result to the clean case.
- 4×2, ch=3, eol on byte 8 (pixel 2, byte 2) → err[0]=1; next write at addr 4; frame ends after line 1; done pulses.
- sof reasserted at byte 7 → err[2]=1; writes restart at addr 0; a full 8-pixel frame completes.
- start with cfg_channel=5 → err[3]=1, done next cycle, no writes. Reset asserted mid-frame → all outputs 0 immediately, no done pulse.
